// File: rtl/sink_checker_pkg.sv
// sink_checker_pkg: shared types and constants for the message sink checker.
//   state_e    - sink FSM states (INIT, RECV, DONE)
//   LFSR_TAPS  - feedback mask for the 16-bit stall LFSR (taps 16,14,13,11)
//   ERR_CNT_W  - width of the saturating mismatch counter
//   sat_inc()  - saturating increment for the mismatch counter
package sink_checker_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int ERR_CNT_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == {ERR_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16_stall.sv
// lfsr16_stall: 16-bit Fibonacci LFSR producing a pseudo-random stall bit.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset, loads seed
//   en     in   advance the LFSR by one step on this clock edge
//   seed   in   16-bit nonzero reset value
//   stall  out  1 when the two low LFSR bits are both zero (about 1 in 4)
module lfsr16_stall
  import sink_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic        stall
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: shift left, feed back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/sink_checker.sv
// sink_checker: val/rdy message sink that compares each accepted message, in
// order, with an expected-message memory loaded by the bench through hierarchy.
// Ports:
//   clk         in   clock
//   reset       in   asynchronous active-low reset
//   val         in   upstream message valid
//   rdy         out  sink ready (state-derived, independent of val)
//   msg         in   upstream message, p_width bits
//   done        out  all p_nmsgs messages accepted
//   error       out  sticky: any mismatch or overflow seen
//   overflow    out  sticky: val asserted while done
//   err_count   out  mismatch count, saturates at 255
//   err_index   out  index of the first mismatching message
//   err_actual  out  message value at the first mismatch
module sink_checker
  import sink_checker_pkg::*;
#(
  parameter int          p_width    = 32,
  parameter int          p_nmsgs    = 4,
  parameter int          p_stall_en = 0,
  parameter logic [15:0] p_seed     = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 val,
  output logic                 rdy,
  input  logic [p_width-1:0]   msg,
  output logic                 done,
  output logic                 error,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] err_index,
  output logic [p_width-1:0]   err_actual
);

  // A zero-message checker still needs a legal one-entry memory.
  localparam int MEM_DEPTH = (p_nmsgs > 0) ? p_nmsgs : 1;
  localparam int IDX_W     = (p_nmsgs > 0) ? $clog2(p_nmsgs + 1) : 1;
  localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((p_nmsgs > 0) ? (p_nmsgs - 1) : 0);

  // Expected messages; written only by the bench, never by this logic or reset.
  logic [p_width-1:0] mem [MEM_DEPTH];

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   error_q, error_d;
  logic                   overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [ERR_CNT_W-1:0]   err_index_q, err_index_d;
  logic [p_width-1:0]     err_actual_q, err_actual_d;

  logic                   lfsr_en_s;
  logic                   stall_raw_s;
  logic                   stall_s;
  logic                   xfer_s;
  logic                   mismatch_s;
  logic [ADDR_W-1:0]      addr_s;

  // The LFSR only runs while receiving, so its sequence is tied to RECV cycles.
  assign lfsr_en_s = (state_q == ST_RECV);

  lfsr16_stall u_stall (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en_s),
    .seed  (p_seed),
    .stall (stall_raw_s)
  );

  assign stall_s = (p_stall_en != 0) ? stall_raw_s : 1'b0;

  // rdy depends only on registered state, never on val.
  assign rdy  = (state_q == ST_RECV) && !stall_s;
  assign done = (state_q == ST_DONE);

  assign xfer_s = val && rdy;
  // idx never exceeds p_nmsgs-1 while in RECV, so the low bits address the memory.
  assign addr_s = idx_q[ADDR_W-1:0];
  // Case inequality so that X/Z on msg is reported as a mismatch.
  assign mismatch_s = (msg !== mem[addr_s]);

  // Next-state and status update logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    error_d      = error_q;
    overflow_d   = overflow_q;
    err_count_d  = err_count_q;
    err_index_d  = err_index_q;
    err_actual_d = err_actual_q;
    case (state_q)
      ST_INIT: begin
        if (p_nmsgs == 0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (xfer_s) begin
          idx_d = idx_q + IDX_W'(1);
          if (mismatch_s) begin
            error_d     = 1'b1;
            err_count_d = sat_inc(err_count_q);
            // Only the first mismatch is captured.
            if (err_count_q == {ERR_CNT_W{1'b0}}) begin
              err_index_d  = ERR_CNT_W'(idx_q);
              err_actual_d = msg;
            end else begin
              err_index_d  = err_index_q;
              err_actual_d = err_actual_q;
            end
          end else begin
            error_d = error_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        // Any further message after completion is an overflow.
        if (val) begin
          overflow_d = 1'b1;
          error_d    = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      idx_q        <= {IDX_W{1'b0}};
      error_q      <= 1'b0;
      overflow_q   <= 1'b0;
      err_count_q  <= {ERR_CNT_W{1'b0}};
      err_index_q  <= {ERR_CNT_W{1'b0}};
      err_actual_q <= {p_width{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      error_q      <= error_d;
      overflow_q   <= overflow_d;
      err_count_q  <= err_count_d;
      err_index_q  <= err_index_d;
      err_actual_q <= err_actual_d;
    end
  end

  assign error      = error_q;
  assign overflow   = overflow_q;
  assign err_count  = err_count_q;
  assign err_index  = err_index_q;
  assign err_actual = err_actual_q;

endmodule

// File: doc/sink_checker.md
Name: sink_checker

Overview:
- Downstream partner of the message Source in unit-level benches.
- Consumes a val/rdy message stream and compares each accepted message, in order, against an expected-message memory that the bench loads hierarchically.
- Reports completion, sticky error status, mismatch count and details of the first mismatch.
- Can inject pseudo-random backpressure on rdy to exercise producer stall logic.

Parameters:
- p_width, 32, message width in bits
- p_nmsgs, 4, number of expected messages (0 allowed)
- p_stall_en, 0, 1 = pseudo-random rdy deassertion enabled
- p_seed, 16'hACE1, nonzero LFSR seed for the stall generator

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- val  in  1  upstream message valid
- rdy  out  1  sink ready
- msg  in  p_width  upstream message
- done  out  1  all p_nmsgs messages accepted
- error  out  1  sticky: any mismatch or overflow seen
- overflow  out  1  sticky: val asserted while in DONE
- err_count  out  8  mismatch count, saturates at 255
- err_index  out  8  index of first mismatch
- err_actual  out  p_width  msg value at first mismatch

Behaviour:
- Expected storage: mem[p_nmsgs] of p_width bits, loaded by the bench through hierarchy. Reset does not clear it; the RTL never writes it.
- Reset (reset==0, asynchronous):
  - state=INIT, idx=0, rdy=0, done=0, error=0, overflow=0, err_count=0, err_index=0, err_actual=0.
  - LFSR loads p_seed.
- States: INIT, RECV, DONE.
  - INIT: on the first posedge after reset release, go to RECV, or to DONE if p_nmsgs==0.
  - RECV: rdy = ~stall. stall is 0 when p_stall_en==0, otherwise stall = (lfsr[1:0]==2'b00).
  - DONE: rdy=0, done=1.
- rdy is registered-state-derived combinational logic with no dependence on val, so there is no combinational val->rdy path.
- Transfer: val & rdy at a posedge.
  - On a transfer, compare msg with mem[idx] using case equality (X/Z on msg counts as a mismatch).
  - Mismatch: error<=1 and err_count<=sat_inc(err_count). If err_count==0 before the increment, also capture err_index<=idx and err_actual<=msg.
  - Every transfer increments idx. A transfer with idx==p_nmsgs-1 moves the state to DONE; done rises the cycle after the last handshake.
- Latency: comparison results are visible one cycle after the handshake edge.
- Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in RECV whether or not a transfer occurs, and freezes in INIT and DONE.
- DONE with val==1 at a posedge: overflow<=1 and error<=1. No other state changes; err_count is unchanged.
- val without rdy: no state change, and msg is ignored.
- Reset asserted mid-stream: all outputs return to reset values immediately, without waiting for clk. The stream restarts at idx 0 after release.
- idx width: $clog2(p_nmsgs+1), minimum 1.

Decomposition:
- Package sink_checker_pkg:
  - state enum (INIT, RECV, DONE)
  - LFSR tap-mask constant
  - err_count width constant (8)
- Sub-module lfsr16_stall: clk, reset, en, seed -> stall bit. It is reusable by a future stalling Source.

Test Plan:
- In-order pass: mem = {0x000F000A, 0x0016000A, 0x00240012, 0x00240015}, the Source sends these with val held high and p_stall_en=0 -> 4 transfers on consecutive cycles; done=1 on the cycle after the 4th; error=0, err_count=0.
- Single mismatch: mem[2]=0x00240012 but 0x00240013 is sent -> error=1, err_count=1, err_index=2, err_actual=0x00240013; done still rises after 4 transfers.
- Multiple mismatches: entries 1 and 3 are wrong -> err_count=2, err_index=1 (first mismatch retained), err_actual = the entry-1 value.
- Backpressure: p_stall_en=1, p_seed=16'hACE1 -> rdy pattern matches a golden LFSR model; exactly 4 handshakes; msg is unchanged while val&!rdy; no errors.
- Overflow and p_nmsgs=0: extra val after done -> overflow=1, error=1, err_count=0. With p_nmsgs=0 -> done=1 one cycle after reset release and rdy never asserts.
- Async reset mid-stream: assert reset low between clock edges after 2 transfers -> done/error/rdy clear with no clk edge; after release, 4 fresh matching messages -> pass.
